// File: rtl/sub_pkg.sv
// Shared constants, stage-register payload and 4-bit lookahead helper
// for the pipelined borrow-lookahead subtractor.
package sub_pkg;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned SLICE  = 16;
  localparam int unsigned STAGES = 4;
  localparam int unsigned GROUP  = 4;
  localparam int unsigned NPIPE  = STAGES - 1;

  // Op in flight: resolved low diff bits plus full operands for the upper slices
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow;
    logic             sx;
    logic             sa;
  } stage_t;

  // Flat two-level lookahead over four generate/propagate pairs: {c4,c3,c2,c1,c0}
  function automatic logic [GROUP:0] la4(input logic [GROUP-1:0] g,
                                         input logic [GROUP-1:0] p,
                                         input logic             c);
    logic [GROUP:0] r;
    r[0] = c;
    r[1] = g[0] | (p[0] & c);
    r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c);
    return r;
  endfunction

endpackage

// File: rtl/bla16.sv
// Combinational 16-bit borrow-lookahead slice: d = a - b - bin, two-level
// group lookahead with no ripple between the four 4-bit groups.
module bla16
  import sub_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  localparam int unsigned NGRP = SLICE / GROUP;

  logic [SLICE-1:0] g, p, bb;
  logic [NGRP-1:0]  gg, gp;
  logic [GROUP:0]   gc, t;

  always_comb begin
    g  = ~a & b;
    p  = ~(a ^ b);
    gg = '0;
    gp = '0;
    bb = '0;
    t  = '0;
    // Group generate/propagate from the bit-level terms
    for (int j = 0; j < int'(NGRP); j++) begin
      t     = la4(g[j*GROUP +: GROUP], p[j*GROUP +: GROUP], 1'b0);
      gg[j] = t[GROUP];
      gp[j] = &p[j*GROUP +: GROUP];
    end
    gc   = la4(gg, gp, bin);
    bout = gc[GROUP];
    for (int j = 0; j < int'(NGRP); j++) begin
      t                      = la4(g[j*GROUP +: GROUP], p[j*GROUP +: GROUP], gc[j]);
      bb[j*GROUP +: GROUP]   = t[GROUP-1:0];
    end
    d = a ^ b ^ bb;
  end

endmodule

// File: rtl/bla_sub64_pipe.sv
// Four-stage pipelined 64-bit borrow-lookahead subtractor with valid/ready
// handshake; the whole pipe stalls when the output is held.
module bla_sub64_pipe
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  stage_t           st_q [NPIPE];
  stage_t           st_d [NPIPE];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0]  sl_a [STAGES];
  logic [SLICE-1:0]  sl_b [STAGES];
  logic [SLICE-1:0]  sl_d [STAGES];
  logic [STAGES-1:0] sl_bi, sl_bo;

  assign in_ready = ~out_valid_q | out_ready;

  // Slice k works on bits [16k+15:16k] with the borrow from stage k-1
  always_comb begin
    sl_a[0]  = a[SLICE-1:0];
    sl_b[0]  = b[SLICE-1:0];
    sl_bi[0] = bin;
    for (int k = 1; k < int'(STAGES); k++) begin
      sl_a[k]  = st_q[k-1].a[k*SLICE +: SLICE];
      sl_b[k]  = st_q[k-1].b[k*SLICE +: SLICE];
      sl_bi[k] = st_q[k-1].borrow;
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
    bla16 u_bla16 (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .bin  (sl_bi[k]),
      .d    (sl_d[k]),
      .bout (sl_bo[k])
    );
  end

  always_comb begin
    st_d[0]        = '0;
    st_d[0].valid  = in_valid;
    st_d[0].d      = WIDTH'(sl_d[0]);
    st_d[0].a      = a;
    st_d[0].b      = b;
    st_d[0].borrow = sl_bo[0];
    st_d[0].sx     = a[WIDTH-1] ^ b[WIDTH-1];
    st_d[0].sa     = a[WIDTH-1];
    for (int k = 1; k < int'(NPIPE); k++) begin
      st_d[k]                      = st_q[k-1];
      st_d[k].d[k*SLICE +: SLICE]  = sl_d[k];
      st_d[k].borrow               = sl_bo[k];
    end
    // Final slice lands directly in the output registers
    out_valid_d = st_q[NPIPE-1].valid;
    diff_d      = {sl_d[STAGES-1], st_q[NPIPE-1].d[WIDTH-SLICE-1:0]};
    bout_d      = sl_bo[STAGES-1];
    ovf_d       = st_q[NPIPE-1].sx & (sl_d[STAGES-1][SLICE-1] ^ st_q[NPIPE-1].sa);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NPIPE); k++) st_q[k] <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (in_ready) begin
      for (int k = 0; k < int'(NPIPE); k++) st_q[k] <= st_d[k];
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bla_sub64_pipe.sv
// Random and directed bench for bla_sub64_pipe against a queue-based
// arithmetic reference model.
module tb_bla_sub64_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  logic [65:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [65:0] prev_out;

  bla_sub64_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, bout, diff} from plain 65-bit arithmetic
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic c);
    logic [64:0] e;
    logic        v;
    e = {1'b0, x} - {1'b0, y} - 65'(c);
    v = (x[63] != y[63]) && (e[63] != x[63]);
    return {v, e};
  endfunction

  // Handshake monitor: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
      if (stall_prev) chk("stall_stable", 128'({ovf, bout, diff}), 128'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 128'(1), 128'(0));
        else chk("result", 128'({ovf, bout, diff}), 128'(exp_q.pop_front()));
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {ovf, bout, diff};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic c);
    logic acc;
    int   n;
    in_valid = 1'b1; a = x; b = y; bin = c;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    if (!acc) chk("send_timeout", 128'(1), 128'(0));
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [63:0] x, input logic [63:0] y, input logic c,
                         input logic [63:0] ed, input logic eb, input logic eo);
    out_ready = 1'b1;
    send(x, y, c);
    for (int i = 0; i < 3; i++) begin
      chk("latency_early", 128'(out_valid), 128'(0));
      step();
    end
    chk("latency_valid", 128'(out_valid), 128'(1));
    chk("dir_diff", 128'(diff), 128'(ed));
    chk("dir_bout", 128'(bout), 128'(eb));
    chk("dir_ovf",  128'(ovf),  128'(eo));
    step();
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin step(); n++; end
    chk("drain", 128'(exp_q.size()), 128'(0));
    step();
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_outputs",   128'({ovf, bout, diff}), 128'(0));
    chk("rst_in_ready",  128'(in_ready), 128'(1));

    // Directed corners
    run_one(64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one(64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_one(64'h0001_0000_0000_0000, 64'h0, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_one(64'h5, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 1'b1, 1'b1);

    // Back-to-back stream: one result per cycle once full
    base      = n_out;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
      if (i % 8 == 0) b = a;
      if (i >= 4) chk("stream_valid", 128'(out_valid), 128'(1));
      step();
    end
    drain();
    chk("stream_count", 128'(n_out - base), 128'(1000));

    // Random valid/ready toggling
    base = n_out;
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
      step();
    end
    drain();

    // Fill, hold backpressure, release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
      chk("fill_ready", 128'(in_ready), 128'(1));
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_ready", 128'(in_ready), 128'(0));
      chk("hold_valid", 128'(out_valid), 128'(1));
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 128'(in_ready), 128'(1));
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      chk("release_valid", 128'(out_valid), 128'(1));
      step();
    end
    chk("release_count", 128'(n_out - base), 128'(4));
    chk("release_empty", 128'(out_valid), 128'(0));
    drain();

    // Reset with three ops in flight
    base      = n_out;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
      step();
    end
    rst = 1'b1;
    a = 64'h1234; b = 64'h1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid",   128'(out_valid), 128'(0));
    chk("flush_outputs", 128'({ovf, bout, diff}), 128'(0));
    chk("flush_ready",   128'(in_ready), 128'(1));
    for (int i = 0; i < 8; i++) step();
    chk("flush_none", 128'(n_out - base), 128'(0));

    run_one(64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
